// File: rtl/o_row_drain.sv
// Round-robin drain of ROW row FIFOs into a single ready/valid stream, COLS words per row per tile.
// Optional O_ROW_DRAIN_LAST_EN adds o_last marking each row's final word of the tile.
module o_row_drain #(
  parameter int unsigned ROW    = 8,
  parameter int unsigned W_DATA = 8,
  parameter int unsigned COLS   = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_start,
  input  logic [ROW-1:0]                           i_fifo_empty,
  input  logic [ROW*W_DATA-1:0]                    i_fifo_data,
  input  logic [ROW-1:0]                           i_fifo_data_valid,
  output logic [ROW-1:0]                           o_read_enable,
  output logic [W_DATA-1:0]                        o_data,
  output logic [((ROW > 1) ? $clog2(ROW) : 1)-1:0] o_row,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic                                     o_busy,
`ifdef O_ROW_DRAIN_LAST_EN
  output logic                                     o_last,
`endif
  output logic                                     o_done
);

  localparam int unsigned RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned CW = $clog2(COLS + 1);
  localparam logic [CW-1:0] COLS_L  = CW'(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [W_DATA-1:0] data;
    logic [RW-1:0]     row;
`ifdef O_ROW_DRAIN_LAST_EN
    logic              last;
`endif
  } entry_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q [ROW];
  logic [CW-1:0]     cnt_d [ROW];
  logic [RW-1:0]     ptr_q, ptr_d;
  logic              infl_q, infl_d;
  logic [RW-1:0]     infl_row_q, infl_row_d;
`ifdef O_ROW_DRAIN_LAST_EN
  logic              infl_last_q, infl_last_d;
`endif
  entry_t            buf_q [2];
  entry_t            buf_d [2];
  logic [1:0]        occ_q, occ_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [W_DATA-1:0] row_word [ROW];
  logic [ROW-1:0]    elig;
  logic              gnt;
  logic [RW-1:0]     gnt_row;
  logic [RW-1:0]     cand;
  logic              pop;
  logic              push;
  logic              credit;
  logic [2:0]        pend;
  logic              all_zero;
  entry_t            push_entry;

  // Per-row data slices (row 0 in the MSBs) and grant eligibility
  for (genvar g = 0; g < ROW; g++) begin : g_row
    assign row_word[g] = i_fifo_data[W_DATA*(ROW-g)-1 -: W_DATA];
    assign elig[g]     = !i_fifo_empty[g] && (cnt_q[g] != '0);
  end

  // Buffer handshake and credit: never more than two words owned between buffer and flight
  always_comb begin
    pop    = (occ_q != 2'd0) && i_ready;
    push   = infl_q && i_fifo_data_valid[infl_row_q];
    pend   = 3'(occ_q) + 3'(infl_q) - 3'(pop);
    credit = (pend < 3'd2);
  end

  // Round-robin search starting at the pointer
  always_comb begin
    gnt     = 1'b0;
    gnt_row = '0;
    cand    = '0;
    if ((state_q == S_RUN) && credit) begin
      for (int k = 0; k < ROW; k++) begin
        cand = RW'((int'(ptr_q) + k) % int'(ROW));
        if (!gnt && elig[cand]) begin
          gnt     = 1'b1;
          gnt_row = cand;
        end
      end
    end
  end

  always_comb begin
    o_read_enable = '0;
    if (gnt) o_read_enable[gnt_row] = 1'b1;
  end

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < ROW; i++) begin
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = row_word[infl_row_q];
    push_entry.row  = infl_row_q;
`ifdef O_ROW_DRAIN_LAST_EN
    push_entry.last = infl_last_q;
`endif
  end

  // Next-state, counters, pointer and in-flight tag
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    infl_d     = 1'b0;
    infl_row_d = infl_row_q;
`ifdef O_ROW_DRAIN_LAST_EN
    infl_last_d = infl_last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          for (int i = 0; i < ROW; i++) cnt_d[i] = COLS_L;
          ptr_d = '0;
        end
      end
      S_RUN: begin
        if (gnt) begin
          cnt_d[gnt_row] = cnt_q[gnt_row] - CW'(1);
          ptr_d          = (gnt_row == ROW_MAX) ? '0 : gnt_row + RW'(1);
          infl_d         = 1'b1;
          infl_row_d     = gnt_row;
`ifdef O_ROW_DRAIN_LAST_EN
          infl_last_d    = (cnt_q[gnt_row] == CW'(1));
`endif
        end else if (all_zero && !infl_q && (occ_q == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Two-entry output buffer; entry 0 is always the head
  always_comb begin
    buf_d = buf_q;
    occ_d = occ_q;
    case ({push, pop})
      2'b10: begin
        buf_d[occ_q[0]] = push_entry;
        occ_d           = occ_q + 2'd1;
      end
      2'b01: begin
        buf_d[0] = buf_q[1];
        occ_d    = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf_d[0] = push_entry;
        end else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = push_entry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < ROW; i++) cnt_q[i] <= '0;
      ptr_q      <= '0;
      infl_q     <= 1'b0;
      infl_row_q <= '0;
`ifdef O_ROW_DRAIN_LAST_EN
      infl_last_q <= 1'b0;
`endif
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      occ_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      infl_q     <= infl_d;
      infl_row_q <= infl_row_d;
`ifdef O_ROW_DRAIN_LAST_EN
      infl_last_q <= infl_last_d;
`endif
      buf_q      <= buf_d;
      occ_q      <= occ_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_data  = buf_q[0].data;
  assign o_row   = buf_q[0].row;
  assign o_valid = (occ_q != 2'd0);
  assign o_busy  = busy_q;
  assign o_done  = done_q;
`ifdef O_ROW_DRAIN_LAST_EN
  assign o_last  = buf_q[0].last && (occ_q != 2'd0);
`endif

endmodule

// File: tb/tb_o_row_drain.sv
// Self-checking bench for o_row_drain: FIFO environment model, per-row order scoreboard,
// vector table of tile scenarios plus latency, back-pressure and reset sequences.
module tb_o_row_drain;
  localparam int ROW  = 8;
  localparam int W    = 8;
  localparam int COLS = 2;
  localparam int RW   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [ROW-1:0]    i_fifo_empty = '1;
  logic [ROW*W-1:0]  i_fifo_data = '0;
  logic [ROW-1:0]    i_fifo_data_valid = '0;
  logic [ROW-1:0]    o_read_enable;
  logic [W-1:0]      o_data;
  logic [RW-1:0]     o_row;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic              o_busy;
  logic              o_done;
`ifdef O_ROW_DRAIN_LAST_EN
  logic              o_last;
`endif

  o_row_drain #(.ROW(ROW), .W_DATA(W), .COLS(COLS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
    .i_fifo_data_valid(i_fifo_data_valid), .o_read_enable(o_read_enable),
    .o_data(o_data), .o_row(o_row), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy),
`ifdef O_ROW_DRAIN_LAST_EN
    .o_last(o_last),
`endif
    .o_done(o_done));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] fifo_q [ROW][$];
  logic [W-1:0] exp_q  [ROW][$];
  int rd_row = -1;
  int reads_total = 0, acc_total = 0, done_cnt = 0, cyc = 0, rdy_pct = 100;
  int row_log[$];
  int acc_cyc[$];
  int row_cnt[ROW];
  bit hold_prev = 0, done_prev = 0;
  logic [W-1:0]  prev_data;
  logic [RW-1:0] prev_row;

  typedef struct {
    logic [7:0] mask0;  // rows loaded at start
    logic [7:0] mask1;  // rows loaded later while running
    int         rdy;    // percent of cycles with i_ready high
    bit         dbl;    // pulse i_start again mid-tile
    bit         seq;    // expect strict 0..7,0..7 back-to-back order
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void upd_empty();
    for (int r = 0; r < ROW; r++) i_fifo_empty[r] = (fifo_q[r].size() == 0);
  endfunction

  // FIFO environment: data appears the cycle after a strobe; other rows get junk and stray valids
  always @(posedge clk) begin
    cyc++;
    #1;
    i_fifo_data_valid = '0;
    for (int r = 0; r < ROW; r++) begin
      i_fifo_data[W*(ROW-r)-1 -: W] = W'($urandom);
      if (r != rd_row && $urandom_range(0, 7) == 0) i_fifo_data_valid[r] = 1'b1;
    end
    if (rd_row >= 0 && fifo_q[rd_row].size() > 0) begin
      i_fifo_data[W*(ROW-rd_row)-1 -: W] = fifo_q[rd_row].pop_front();
      i_fifo_data_valid[rd_row] = 1'b1;
    end
    rd_row = -1;
    upd_empty();
  end

  always @(posedge clk) begin
    #3;
    i_ready = ($urandom_range(0, 99) < rdy_pct);
  end

  // Monitor: strobe legality, scoreboard, hold-under-backpressure, credit bound, done/busy
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rden_onehot0", $onehot0(o_read_enable), 1);
      if (o_read_enable != '0) begin
        for (int r = 0; r < ROW; r++) begin
          if (o_read_enable[r]) begin
            chk("rden_nonempty", fifo_q[r].size() > 0, 1);
            rd_row = r;
          end
        end
        reads_total++;
      end
      if (hold_prev) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, prev_data);
        chk("hold_row", o_row, prev_row);
      end
      if (o_valid && i_ready) begin
        acc_total++;
        if (exp_q[o_row].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_unexpected row=%0d actual=%0h required=none", o_row, o_data);
        end else begin
          chk("data", o_data, exp_q[o_row].pop_front());
        end
        row_log.push_back(int'(o_row));
        acc_cyc.push_back(cyc);
        row_cnt[o_row]++;
`ifdef O_ROW_DRAIN_LAST_EN
        chk("last", o_last, row_cnt[o_row] == COLS);
`endif
      end
      chk("outstanding_le2", (reads_total - acc_total) <= 2, 1);
      hold_prev = o_valid && !i_ready;
      prev_data = o_data;
      prev_row  = o_row;
      if (done_prev) chk("busy_after_done", o_busy, 0);
      done_prev = o_done;
      if (o_done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input logic [7:0] mask);
    logic [W-1:0] w;
    for (int r = 0; r < ROW; r++) begin
      if (mask[r]) begin
        for (int c = 0; c < COLS; c++) begin
          w = W'($urandom);
          fifo_q[r].push_back(w);
          exp_q[r].push_back(w);
        end
      end
    end
    upd_empty();
  endtask

  task automatic begin_tile();
    row_log.delete();
    acc_cyc.delete();
    for (int r = 0; r < ROW; r++) row_cnt[r] = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done_and_check();
    int n = 0;
    int cnt;
    int left = 0;
    while (done_cnt == 0 && n < 1000) begin
      step();
      n++;
    end
    chk("done_timeout", done_cnt != 0, 1);
    repeat (4) step();
    chk("done_pulses", done_cnt, 1);
    chk("tile_words", row_log.size(), ROW * COLS);
    for (int r = 0; r < ROW; r++) begin
      cnt = 0;
      foreach (row_log[i]) if (row_log[i] == r) cnt++;
      chk("row_words", cnt, COLS);
      left += exp_q[r].size();
    end
    chk("words_left", left, 0);
  endtask

  task automatic do_reset_flush();
    for (int r = 0; r < ROW; r++) begin
      fifo_q[r].delete();
      exp_q[r].delete();
    end
    rd_row = -1;
    hold_prev = 0;
    done_prev = 0;
    reads_total = 0;
    acc_total = 0;
    upd_empty();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", o_valid, 0);
    chk("rst_rden", o_read_enable, 0);
    chk("rst_data", o_data, 0);
    chk("rst_row", o_row, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
  endtask

  initial begin
    vecs[0] = '{8'hff, 8'h00, 100, 1'b0, 1'b1};
    vecs[1] = '{8'h24, 8'hdb, 100, 1'b0, 1'b0};
    vecs[2] = '{8'hff, 8'h00,  50, 1'b0, 1'b0};
    vecs[3] = '{8'hff, 8'h00, 100, 1'b1, 1'b0};
    vecs[4] = '{8'h0f, 8'hf0,  70, 1'b1, 1'b0};
    vecs[5] = '{8'hff, 8'h00,  30, 1'b0, 1'b0};

    repeat (3) step();
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (2) step();

    foreach (vecs[v]) begin
      rdy_pct = vecs[v].rdy;
      begin_tile();
      fill(vecs[v].mask0);
      pulse_start();
      if (vecs[v].dbl) begin
        repeat (3) step();
        pulse_start();
      end
      if (vecs[v].mask1 != 8'h00) begin
        repeat (60) step();
        chk("early_words", row_log.size(), $countones(vecs[v].mask0) * COLS);
        chk("busy_waiting", o_busy, 1);
        if (vecs[v].mask0 == 8'h24) begin
          chk("sparse_first", row_log[0], 2);
          chk("sparse_second", row_log[1], 5);
        end
        fill(vecs[v].mask1);
      end
      wait_done_and_check();
      if (vecs[v].seq && row_log.size() == ROW * COLS) begin
        for (int i = 0; i < ROW * COLS; i++) chk("rr_order", row_log[i], i % ROW);
        chk("back_to_back", acc_cyc[ROW*COLS-1] - acc_cyc[0], ROW * COLS - 1);
      end
    end

    // Start-to-strobe and start-to-valid latency
    rdy_pct = 100;
    begin_tile();
    fill(8'hff);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("lat_rden", o_read_enable, 8'h01);
    chk("lat_valid_e0", o_valid, 0);
    step();
    chk("lat_valid_e1", o_valid, 0);
    step();
    chk("lat_valid_e2", o_valid, 1);
    chk("lat_row", o_row, 0);
    wait_done_and_check();

    // Ten-cycle stall mid-tile
    begin_tile();
    fill(8'hff);
    pulse_start();
    repeat (4) step();
    rdy_pct = 0;
    repeat (10) step();
    chk("stall_outstanding", reads_total - acc_total, 2);
    chk("stall_valid", o_valid, 1);
    rdy_pct = 100;
    wait_done_and_check();

    // Reset with a full buffer, then a clean tile
    rdy_pct = 0;
    begin_tile();
    fill(8'hff);
    pulse_start();
    repeat (6) step();
    chk("prerst_valid", o_valid, 1);
    chk("prerst_outstanding", reads_total - acc_total, 2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    do_reset_flush();
    repeat (2) step();
    rst_n = 1'b1;
    rdy_pct = 100;
    repeat (2) step();
    chk("postrst_busy", o_busy, 0);
    begin_tile();
    fill(8'hff);
    pulse_start();
    wait_done_and_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/o_row_drain.md
O_ROW_DRAIN -- requirements
Module: o_row_drain

Interface
REQ-001 Parameters (name, default, meaning): ROW, 8, number of row FIFOs drained | W_DATA, 8, data word width | COLS, 8, words drained per row per tile (>=1).
REQ-002 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  pulse; begins draining one tile (COLS words from every row).
REQ-005 i_fifo_empty  input  ROW  per-row empty flag; bit i = row i.
REQ-006 i_fifo_data  input  ROW*W_DATA  row read data; row i at bits [W_DATA*(ROW-i)-1 -: W_DATA], row 0 in the MSBs.
REQ-007 i_fifo_data_valid  input  ROW  per-row read-data-valid; high the cycle after that row's read enable.
REQ-008 o_read_enable  output  ROW  per-row read strobe; at most one bit high per cycle.
REQ-009 o_data  output  W_DATA  output word.
REQ-010 o_row  output  $clog2(ROW) (min 1)  row index of o_data.
REQ-011 o_valid  output  1  o_data/o_row valid.
REQ-012 i_ready  input  1  downstream accepts; transfer when o_valid && i_ready.
REQ-013 o_busy  output  1  high in RUN and DONE.
REQ-014 o_done  output  1  one-cycle pulse at tile completion.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on i_start; RUN->DONE when all row counters are zero, no read in flight and output buffer empty; DONE->IDLE unconditionally after one cycle.
REQ-016 i_start in RUN or DONE is ignored.
REQ-017 On IDLE->RUN every per-row remaining counter loads COLS and the round-robin pointer loads 0.
REQ-018 In RUN, each cycle the block grants the first row at or after the pointer (wrapping mod ROW) with !i_fifo_empty, counter>0 and credit available; the grant drives o_read_enable one-hot combinationally.
REQ-019 Credit available when buffer occupancy + in-flight reads - (o_valid && i_ready) < 2.
REQ-020 On a grant to row r: row r counter decrements; pointer becomes (r+1) mod ROW; r registered as the in-flight row tag.
REQ-021 No grant: o_read_enable = 0, pointer unchanged.
REQ-022 Cycle after a grant to r, if i_fifo_data_valid[r]=1, row r's word and tag r are pushed into a 2-entry output buffer; i_fifo_data_valid bits with no matching in-flight read are ignored.
REQ-023 Buffer head drives o_data/o_row/o_valid; o_data and o_row stay stable while o_valid && !i_ready.
REQ-024 Simultaneous push and pop allowed at any occupancy; sustained throughput one word per cycle with i_ready=1 and rows non-empty.
REQ-025 Latency: i_start sampled at edge E0, row 0 non-empty, i_ready=1 -> o_read_enable[0] high in cycle after E0, o_valid high after E2.
REQ-026 Row counters never decrement below zero; a row with counter 0 is never granted even if non-empty.
REQ-027 o_done is high exactly during the DONE cycle; o_busy = (state != IDLE).

Reset
REQ-028 i_rst_n low asynchronously forces IDLE, counters 0, pointer 0, buffer empty, no read in flight; o_read_enable=0, o_valid=0, o_data=0, o_row=0, o_busy=0, o_done=0.
REQ-029 Reset mid-tile discards buffered and in-flight words; a data-valid arriving in the first cycle after reset release is ignored.

Configuration
REQ-030 Macro O_ROW_DRAIN_LAST_EN: when defined, adds output o_last (1 bit), high with o_valid on the word that is the final (COLS-th) word of its row in the tile, tagged at grant time and stored in the buffer; reset value 0.
REQ-031 Without O_ROW_DRAIN_LAST_EN, the o_last port and its storage do not exist; all other behaviour is identical.

Verification
REQ-032 ROW=8, COLS=2, all rows preloaded, i_ready=1, pulse i_start -> 16 words on o_row 0,1,...,7,0,...,7, consecutive cycles, then o_done one cycle, o_busy low next cycle.
REQ-033 Only rows 2 and 5 non-empty, COLS=1 -> o_row sequence 2,5; rows with empty FIFOs never strobed; FSM stays in RUN until the other rows supply their word.
REQ-034 i_ready held low 10 cycles mid-tile -> o_data/o_row frozen, o_read_enable stops after at most 2 outstanding words, no word lost or duplicated after i_ready returns.
REQ-035 i_start pulsed again during RUN -> ignored; total words still ROW*COLS, single o_done.
REQ-036 i_rst_n asserted with buffer holding 2 words -> o_valid=0, o_read_enable=0 immediately; after release IDLE, new i_start drains a full tile correctly.
REQ-037 With O_ROW_DRAIN_LAST_EN, COLS=3 -> o_last high on the third word of each row only, 8 assertions per tile.
